// File: rtl/microsequencer_pkg.sv
// rtl/microsequencer_pkg.sv - shared microcode word layout, fetch words and widths
package microsequencer_pkg;

  localparam int OP_BITS = 8;
  localparam int T_BITS  = 3;
  localparam int UA_BITS = OP_BITS + T_BITS;
  localparam int W_BITS  = 16;

  localparam logic [T_BITS-1:0] T_LAST = '1;

  // Word layout: [15] EO_bar, [14:12] out select, [11] NY, [10] PP, [7:4] in select
  localparam int EO_BAR_BIT  = 15;
  localparam int OUT_SEL_LSB = 12;
  localparam int IN_SEL_LSB  = 4;

  localparam logic [W_BITS-1:0] vEO = 16'h8000;
  localparam logic [W_BITS-1:0] vNY = 16'h0800;
  localparam logic [W_BITS-1:0] vPP = 16'h0400;

  localparam logic [W_BITS-1:0] vPO = 16'h0000;
  localparam logic [W_BITS-1:0] vMO = 16'h3000;
  localparam logic [W_BITS-1:0] vDO = 16'h1000;
  localparam logic [W_BITS-1:0] vAI = 16'h0020;
  localparam logic [W_BITS-1:0] vII = 16'h0040;
  localparam logic [W_BITS-1:0] vYI = 16'h0010;
  localparam logic [W_BITS-1:0] vDI = 16'h0030;

  localparam logic [W_BITS-1:0] FETCH0 = vEO | vPO | vAI;
  localparam logic [W_BITS-1:0] FETCH1 = vEO | vMO | vII | vPP;

  typedef enum logic [T_BITS-1:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6,
    T7 = 3'd7
  } tstate_e;

  function automatic logic [W_BITS-1:0] select_uinstr(
    input logic [T_BITS-1:0] t,
    input logic [W_BITS-1:0] rom_word
  );
    case (t)
      T0:      return FETCH0;
      T1:      return FETCH1;
      default: return rom_word;
    endcase
  endfunction

endpackage

// File: rtl/microsequencer_tstate_counter.sv
// rtl/microsequencer_tstate_counter.sv - T-state counter with clear, hold and wrap detect
module tstate_counter
  import microsequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_bar,
  input  logic              rt,
  input  logic              stall,
  output logic [T_BITS-1:0] t,
  output logic [T_BITS-1:0] t_next,
  output logic              wrap
);

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      t <= '0;
    end else begin
      t <= t_next;
    end
  end

  // rt wins over the wrap, so a T7 that carries rt is a clean end of instruction
  always_comb begin
    t_next = t;
    wrap   = 1'b0;
    if (!stall) begin
      if (rt) begin
        t_next = '0;
      end else if (t == T_LAST) begin
        t_next = '0;
        wrap   = 1'b1;
      end else begin
        t_next = t + 1'b1;
      end
    end
  end

endmodule

// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - IR/T-state tracking, microcode ROM addressing and uinstr mux
module microsequencer
  import microsequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_bar,
  input  logic [W_BITS-1:0]  bus_in,
  input  logic               ii_bar,
  input  logic               rt,
  input  logic               stall,
  output logic [UA_BITS-1:0] urom_addr,
  input  logic [W_BITS-1:0]  urom_data,
  output logic [W_BITS-1:0]  uinstr,
  output logic [T_BITS-1:0]  tstate,
  output logic [OP_BITS-1:0] ir,
  output logic               instr_start,
  output logic               ucode_err
);

  logic [T_BITS-1:0]  t_next;
  logic               wrap;
  logic [OP_BITS-1:0] ir_next;

  tstate_counter u_tstate_counter (
    .clk       (clk),
    .reset_bar (reset_bar),
    .rt        (rt),
    .stall     (stall),
    .t         (tstate),
    .t_next    (t_next),
    .wrap      (wrap)
  );

  always_comb begin
    ir_next = ir;
    if (!stall && !ii_bar) begin
      ir_next = bus_in[W_BITS-1 -: OP_BITS];
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      ir        <= '0;
      ucode_err <= 1'b0;
    end else begin
      ir        <= ir_next;
      ucode_err <= wrap;
    end
  end

  // The ROM registers this address on the same edge that loads tstate/ir
  assign urom_addr   = {ir_next, t_next};
  assign uinstr      = select_uinstr(tstate, urom_data);
  assign instr_start = (tstate == T0);

endmodule

// File: tb/tb_microsequencer.sv
// tb/tb_microsequencer.sv - directed self-checking bench for microsequencer
module tb_microsequencer;

  logic        clk = 1'b0;
  logic        reset_bar = 1'b0;
  logic [15:0] bus_in = 16'h0000;
  logic        ii_bar = 1'b1;
  logic        rt = 1'b0;
  logic        stall = 1'b0;
  logic [10:0] urom_addr;
  logic [15:0] urom_data;
  logic [15:0] uinstr;
  logic [2:0]  tstate;
  logic [7:0]  ir;
  logic        instr_start;
  logic        ucode_err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  microsequencer dut (
    .clk         (clk),
    .reset_bar   (reset_bar),
    .bus_in      (bus_in),
    .ii_bar      (ii_bar),
    .rt          (rt),
    .stall       (stall),
    .urom_addr   (urom_addr),
    .urom_data   (urom_data),
    .uinstr      (uinstr),
    .tstate      (tstate),
    .ir          (ir),
    .instr_start (instr_start),
    .ucode_err   (ucode_err)
  );

  // Synchronous ROM model: one NY word, every other word tags its own address
  function automatic logic [15:0] rom_word(input logic [10:0] a);
    if (a == 11'h152) return 16'h8800;
    return 16'h8000 | {5'b0, a};
  endfunction

  always @(posedge clk) urom_data <= rom_word(urom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to_t(input logic [2:0] target);
    int k;
    k = 0;
    while (tstate !== target && k < 9) begin
      tick();
      k++;
    end
    n_checks++;
    if (tstate !== target) begin
      n_fail++;
      $display("FAIL go_to_t: tstate=%0d required=%0d", tstate, target);
    end
  endtask

  task automatic test_reset();
    reset_bar = 1'b0;
    tick();
    tick();
    #2 reset_bar = 1'b1;
    #1;
    n_checks++; if (tstate !== 3'd0) begin n_fail++; $display("FAIL reset_tstate: got %0d want 0", tstate); end
    n_checks++; if (ir !== 8'h00) begin n_fail++; $display("FAIL reset_ir: got %h want 00", ir); end
    n_checks++; if (uinstr !== 16'h8020) begin n_fail++; $display("FAIL reset_uinstr: got %h want 8020", uinstr); end
    n_checks++; if (instr_start !== 1'b1) begin n_fail++; $display("FAIL reset_instr_start: got %b want 1", instr_start); end
    n_checks++; if (ucode_err !== 1'b0) begin n_fail++; $display("FAIL reset_ucode_err: got %b want 0", ucode_err); end
  endtask

  task automatic test_fetch_fields();
    n_checks++; if (uinstr[15] !== 1'b1) begin n_fail++; $display("FAIL t0_eo_bar: got %b want 1", uinstr[15]); end
    n_checks++; if (uinstr[14:12] !== 3'd0) begin n_fail++; $display("FAIL t0_po_sel: got %0d want 0", uinstr[14:12]); end
    n_checks++; if (uinstr[7:4] !== 4'd2) begin n_fail++; $display("FAIL t0_ai_sel: got %0d want 2", uinstr[7:4]); end
    tick();
    n_checks++; if (uinstr !== 16'hB440) begin n_fail++; $display("FAIL t1_word: got %h want b440", uinstr); end
    n_checks++; if (uinstr[14:12] !== 3'd3) begin n_fail++; $display("FAIL t1_mo_sel: got %0d want 3", uinstr[14:12]); end
    n_checks++; if (uinstr[7:4] !== 4'd4) begin n_fail++; $display("FAIL t1_ii_sel: got %0d want 4", uinstr[7:4]); end
    n_checks++; if (uinstr[10] !== 1'b1) begin n_fail++; $display("FAIL t1_pp: got %b want 1", uinstr[10]); end
    n_checks++; if (uinstr[15] !== 1'b1) begin n_fail++; $display("FAIL t1_eo_inactive: got %b want 1", uinstr[15]); end
    rt = 1'b1;
    tick();
    rt = 1'b0;
    n_checks++; if (tstate !== 3'd0) begin n_fail++; $display("FAIL rt_in_t1: got %0d want 0", tstate); end
  endtask

  task automatic test_fetch_decode();
    tick();
    bus_in = 16'h2A00;
    ii_bar = 1'b0;
    #1;
    n_checks++; if (urom_addr !== 11'h152) begin n_fail++; $display("FAIL t1_urom_addr: got %h want 152", urom_addr); end
    tick();
    ii_bar = 1'b1;
    bus_in = 16'h0000;
    n_checks++; if (ir !== 8'h2A) begin n_fail++; $display("FAIL ir_latched: got %h want 2a", ir); end
    n_checks++; if (tstate !== 3'd2) begin n_fail++; $display("FAIL t2_tstate: got %0d want 2", tstate); end
    n_checks++; if (uinstr !== 16'h8800) begin n_fail++; $display("FAIL t2_uinstr: got %h want 8800", uinstr); end
    rt = 1'b1;
    #1;
    n_checks++; if (urom_addr !== 11'h150) begin n_fail++; $display("FAIL rt_urom_addr: got %h want 150", urom_addr); end
    tick();
    rt = 1'b0;
    n_checks++; if (tstate !== 3'd0) begin n_fail++; $display("FAIL rt_tstate: got %0d want 0", tstate); end
    n_checks++; if (uinstr !== 16'h8020) begin n_fail++; $display("FAIL rt_uinstr: got %h want 8020", uinstr); end
  endtask

  task automatic test_wrap();
    for (int i = 1; i < 8; i++) begin
      tick();
      n_checks++;
      if (tstate !== i[2:0]) begin n_fail++; $display("FAIL wrap_step: got %0d want %0d", tstate, i); end
    end
    n_checks++; if (ucode_err !== 1'b0) begin n_fail++; $display("FAIL err_before_wrap: got %b want 0", ucode_err); end
    tick();
    n_checks++; if (tstate !== 3'd0) begin n_fail++; $display("FAIL wrap_tstate: got %0d want 0", tstate); end
    n_checks++; if (ucode_err !== 1'b1) begin n_fail++; $display("FAIL wrap_err: got %b want 1", ucode_err); end
    tick();
    n_checks++; if (ucode_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err_pulse: got %b want 0", ucode_err); end
    go_to_t(3'd7);
    rt = 1'b1;
    tick();
    rt = 1'b0;
    n_checks++; if (tstate !== 3'd0) begin n_fail++; $display("FAIL rt_t7_tstate: got %0d want 0", tstate); end
    n_checks++; if (ucode_err !== 1'b0) begin n_fail++; $display("FAIL rt_t7_err: got %b want 0", ucode_err); end
  endtask

  task automatic test_stall();
    go_to_t(3'd3);
    n_checks++; if (uinstr !== 16'h8153) begin n_fail++; $display("FAIL t3_uinstr: got %h want 8153", uinstr); end
    stall = 1'b1;
    rt = 1'b1;
    ii_bar = 1'b0;
    bus_in = 16'h5500;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (urom_addr !== 11'h153) begin n_fail++; $display("FAIL stall_addr: got %h want 153", urom_addr); end
      tick();
      n_checks++; if (tstate !== 3'd3) begin n_fail++; $display("FAIL stall_tstate: got %0d want 3", tstate); end
      n_checks++; if (ir !== 8'h2A) begin n_fail++; $display("FAIL stall_ir: got %h want 2a", ir); end
      n_checks++; if (uinstr !== 16'h8153) begin n_fail++; $display("FAIL stall_uinstr: got %h want 8153", uinstr); end
    end
    stall = 1'b0;
    ii_bar = 1'b1;
    tick();
    rt = 1'b0;
    n_checks++; if (tstate !== 3'd0) begin n_fail++; $display("FAIL stall_release_rt: got %0d want 0", tstate); end
    n_checks++; if (ir !== 8'h2A) begin n_fail++; $display("FAIL stall_release_ir: got %h want 2a", ir); end
  endtask

  task automatic test_stall_at_t7();
    go_to_t(3'd7);
    stall = 1'b1;
    tick();
    n_checks++; if (tstate !== 3'd7) begin n_fail++; $display("FAIL stall_t7_hold: got %0d want 7", tstate); end
    n_checks++; if (ucode_err !== 1'b0) begin n_fail++; $display("FAIL stall_t7_err: got %b want 0", ucode_err); end
    stall = 1'b0;
    tick();
    n_checks++; if (ucode_err !== 1'b1) begin n_fail++; $display("FAIL stall_t7_release_err: got %b want 1", ucode_err); end
  endtask

  task automatic test_reset_mid();
    go_to_t(3'd4);
    #2 reset_bar = 1'b0;
    #1;
    n_checks++; if (tstate !== 3'd0) begin n_fail++; $display("FAIL async_tstate: got %0d want 0", tstate); end
    n_checks++; if (ir !== 8'h00) begin n_fail++; $display("FAIL async_ir: got %h want 00", ir); end
    n_checks++; if (uinstr !== 16'h8020) begin n_fail++; $display("FAIL async_uinstr: got %h want 8020", uinstr); end
    reset_bar = 1'b1;
    tick();
    n_checks++; if (tstate !== 3'd1) begin n_fail++; $display("FAIL post_reset_step: got %0d want 1", tstate); end
  endtask

  initial begin
    test_reset();
    test_fetch_fields();
    test_fetch_decode();
    test_wrap();
    test_stall();
    test_stall_at_t7();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
